// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Multi-channel LED pattern generator. A single shared prescaler
// sets the step rate for NUM_LED outputs. The pattern is selected at run time
// from off / blink / chase / ping-pong.
//
// Parameters
//   NUM_LED      number of LED channels (>= 1)
//   STEP_CYCLES  clock cycles per pattern step (>= 2)
//   CNT_W        prescaler width, 2**CNT_W >= STEP_CYCLES
//
// Ports
//   CLK       system clock
//   RST_n     asynchronous active-low reset
//   En_i      1 = pattern advances, 0 = freeze (prescaler and pattern hold)
//   Mode_i    00 off, 01 blink, 10 chase, 11 ping-pong
//   Duty_i    brightness, only used when LED_PWM_EN is defined
//   Step_Out  one-cycle pulse in the cycle a new pattern step appears
//   LED_Out   registered LED drive, 1 = lit
//
// Build option
//   LED_PWM_EN  when defined, a free-running 4-bit PWM counter gates LED_Out
//               with (pwm_cnt <= Duty_i). When undefined, Duty_i is ignored.
//               The port list is the same in both builds.
// -----------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int unsigned NUM_LED     = 4,
  parameter int unsigned STEP_CYCLES = 2500000,
  parameter int unsigned CNT_W       = 22
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               En_i,
  input  logic [1:0]         Mode_i,
  input  logic [3:0]         Duty_i,
  output logic               Step_Out,
  output logic [NUM_LED-1:0] LED_Out
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_CHASE = 2'b10,
    MODE_PING  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [NUM_LED-1:0] PAT_BIT0  = NUM_LED'(1);

  // State
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  mode_e              mode_q,    mode_d;
  logic [NUM_LED-1:0] pattern_q, pattern_d;
  dir_e               dir_q,     dir_d;
  logic               step_q,    step_d;
  logic [NUM_LED-1:0] led_q,     led_d;
  mode_e              mode_in;

`ifdef LED_PWM_EN
  logic [3:0]         pwm_cnt_q, pwm_cnt_d;
  logic               pwm_on;
`else
  logic               duty_unused;
  assign duty_unused = ^Duty_i;
`endif

  assign mode_in = mode_e'(Mode_i);

  // Pattern loaded when a mode is entered.
  function automatic logic [NUM_LED-1:0] init_pattern(input mode_e m);
    logic [NUM_LED-1:0] p;
    case (m)
      MODE_OFF:   p = '0;
      MODE_BLINK: p = '1;
      default:    p = PAT_BIT0;
    endcase
    return p;
  endfunction

  // Next-state logic
  always_comb begin
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    step_d    = 1'b0;

    if (mode_in != mode_q) begin
      // A mode change takes priority over a coinciding prescaler wrap. It
      // restarts the step period and does not depend on En_i.
      mode_d    = mode_in;
      cnt_d     = '0;
      pattern_d = init_pattern(mode_in);
      dir_d     = DIR_UP;
    end else if (En_i) begin
      if (cnt_q == STEP_LAST) begin
        cnt_d  = '0;
        step_d = 1'b1;
        case (mode_q)
          MODE_OFF:   pattern_d = '0;
          MODE_BLINK: pattern_d = ~pattern_q;
          // The right shift by NUM_LED-1 carries the MSB back to bit0. This
          // form is also correct for NUM_LED == 1, where it holds the pattern.
          MODE_CHASE: pattern_d = (pattern_q << 1) | (pattern_q >> (NUM_LED - 1));
          MODE_PING: begin
            if (NUM_LED == 1) begin
              pattern_d = pattern_q;
            end else if (dir_q == DIR_UP) begin
              pattern_d = pattern_q << 1;
              // Reverse when the end is reached, so the next step moves back.
              if (pattern_d[NUM_LED-1]) dir_d = DIR_DOWN;
            end else begin
              pattern_d = pattern_q >> 1;
              if (pattern_d[0]) dir_d = DIR_UP;
            end
          end
          default: pattern_d = '0;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

`ifdef LED_PWM_EN
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    pwm_on    = (pwm_cnt_q <= Duty_i);
    led_d     = pattern_d & {NUM_LED{pwm_on}};
`else
    led_d     = pattern_d;
`endif
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q     <= '0;
      mode_q    <= MODE_OFF;
      pattern_q <= '0;
      dir_q     <= DIR_UP;
      step_q    <= 1'b0;
      led_q     <= '0;
`ifdef LED_PWM_EN
      pwm_cnt_q <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      led_q     <= led_d;
`ifdef LED_PWM_EN
      pwm_cnt_q <= pwm_cnt_d;
`endif
    end
  end

  assign Step_Out = step_q;
  assign LED_Out  = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Self-checking bench for led_pattern_gen with NUM_LED=4, STEP_CYCLES=10.
// The reference model tracks the step index since the last mode load. It
// derives each pattern arithmetically from that index: blink from its parity,
// chase from index mod N, and ping-pong from a triangle fold of index mod
// 2(N-1).
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int unsigned N    = 4;
  localparam int unsigned STEP = 10;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic [1:0]   mode  = 2'b00;
  logic [3:0]   duty  = 4'd0;
  logic         step_out;
  logic [N-1:0] led;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LED    (N),
    .STEP_CYCLES(STEP),
    .CNT_W      (4)
  ) dut (
    .CLK     (clk),
    .RST_n   (rst_n),
    .En_i    (en),
    .Mode_i  (mode),
    .Duty_i  (duty),
    .Step_Out(step_out),
    .LED_Out (led)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Reference model state
  int unsigned  m_mode = 0;
  int unsigned  m_cnt  = 0;
  int unsigned  m_k    = 0;
  logic         m_step = 1'b0;
  logic [N-1:0] m_led  = '0;
`ifdef LED_PWM_EN
  int unsigned  m_pwm  = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_pattern(input int unsigned md, input int unsigned k);
    int unsigned p;
    case (md)
      0: return '0;
      1: return (k % 2 == 0) ? {N{1'b1}} : {N{1'b0}};
      2: return N'(1) << (k % N);
      default: begin
        p = k % (2 * (N - 1));
        if (p >= N) p = 2 * (N - 1) - p;
        return N'(1) << p;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_k = 0; m_step = 1'b0; m_led = '0;
`ifdef LED_PWM_EN
    m_pwm = 0;
`endif
  endtask

  // Model update for one rising edge, using the inputs held across that edge.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (int'(mode) != int'(m_mode)) begin
        m_mode = mode; m_cnt = 0; m_k = 0; m_step = 1'b0;
      end else if (en) begin
        if (m_cnt == STEP - 1) begin
          m_cnt = 0; m_k++; m_step = 1'b1;
        end else begin
          m_cnt++; m_step = 1'b0;
        end
      end else begin
        m_step = 1'b0;
      end
      m_led = ref_pattern(m_mode, m_k);
`ifdef LED_PWM_EN
      if (!(m_pwm <= duty)) m_led = '0;
      m_pwm = (m_pwm + 1) % 16;
`endif
    end
  endtask

  // Drive the inputs, run one clock, and check both outputs against the model.
  task automatic tick(input logic e, input logic [1:0] md, input logic [3:0] dt);
    en = e; mode = md; duty = dt;
    @(posedge clk);
    model_edge();
    #1;
    chk("led", led, m_led);
    chk("step", step_out, m_step);
  endtask

  // Count clocks until the next Step_Out pulse. The wait is bounded.
  task automatic clocks_to_step(input string tag, input int unsigned exp_n,
                                input logic e, input logic [1:0] md, input logic [3:0] dt);
    int unsigned c = 0;
    do begin
      tick(e, md, dt);
      c++;
    end while (!step_out && c < 3 * STEP);
    chk(tag, c, exp_n);
  endtask

  // Assert reset between clock edges. Outputs must clear without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_led", led, '0);
    chk("arst_step", step_out, 1'b0);
    tick(en, mode, duty);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned pulses;
    int unsigned hi;
    int unsigned len;
    logic [1:0]  r_md;
    logic        r_en;
    logic [3:0]  r_dt;

    // Reset with chase requested
    rst_n = 1'b0;
    repeat (10) tick(1'b1, 2'b10, 4'd15);
    chk("rst_led", led, '0);
    chk("rst_step", step_out, 1'b0);
    rst_n = 1'b1;
    tick(1'b1, 2'b10, 4'd15);
    chk("chase_init", led, 4'b0001);
    repeat (9) tick(1'b1, 2'b10, 4'd15);
    chk("chase_pre_step", step_out, 1'b0);
    tick(1'b1, 2'b10, 4'd15);
    chk("chase_s1_led", led, 4'b0010);
    chk("chase_s1_step", step_out, 1'b1);
    repeat (3 * STEP) tick(1'b1, 2'b10, 4'd15);
    chk("chase_wrap", led, 4'b0001);

    // Ping-pong: 8 steps
    tick(1'b1, 2'b11, 4'd15);
    chk("pp_init", led, 4'b0001);
    pulses = 0;
    repeat (8 * STEP) begin
      tick(1'b1, 2'b11, 4'd15);
      if (step_out) pulses++;
    end
    chk("pp_pulses", pulses, 8);
    chk("pp_end", led, 4'b0100);

    // Async reset while LED_Out = 0100
    async_reset();

    // Blink and freeze
    tick(1'b1, 2'b01, 4'd15);
    chk("blink_on", led, 4'b1111);
    repeat (STEP) tick(1'b1, 2'b01, 4'd15);
    chk("blink_off", led, 4'b0000);
    repeat (3) tick(1'b1, 2'b01, 4'd15);
    repeat (25) tick(1'b0, 2'b01, 4'd15);
    chk("frz_led", led, 4'b0000);
    chk("frz_step", step_out, 1'b0);
    clocks_to_step("blink_resume", STEP - 3, 1'b1, 2'b01, 4'd15);
    chk("blink_resume_led", led, 4'b1111);

    // Mode change on the edge where the prescaler would wrap
    tick(1'b1, 2'b10, 4'd15);
    repeat (STEP - 1) tick(1'b1, 2'b10, 4'd15);
    tick(1'b1, 2'b11, 4'd15);
    chk("col_step", step_out, 1'b0);
    chk("col_led", led, 4'b0001);
    clocks_to_step("col_next", STEP, 1'b1, 2'b11, 4'd15);

    // Brightness in a frozen lit blink phase
    tick(1'b1, 2'b01, 4'd3);
    hi = 0;
    repeat (16) begin
      tick(1'b0, 2'b01, 4'd3);
      if (led[0]) hi++;
    end
`ifdef LED_PWM_EN
    chk("duty3_high", hi, 4);
`else
    chk("duty3_high", hi, 16);
`endif
    hi = 0;
    repeat (16) begin
      tick(1'b0, 2'b01, 4'd15);
      if (led[0]) hi++;
    end
    chk("duty15_high", hi, 16);
    hi = 0;
    repeat (16) begin
      tick(1'b0, 2'b01, 4'd0);
      if (led[0]) hi++;
    end
`ifdef LED_PWM_EN
    chk("duty0_high", hi, 1);
`else
    chk("duty0_high", hi, 16);
`endif

    // Random phases
    repeat (60) begin
      r_md = 2'($urandom_range(0, 3));
      r_en = ($urandom_range(0, 3) != 0);
      r_dt = 4'($urandom_range(0, 15));
      len  = $urandom_range(1, 30);
      repeat (len) tick(r_en, r_md, r_dt);
      if ($urandom_range(0, 9) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
